mcse_ahb_fw_responder: RTL and testbench
========================================

Name: mcse_ahb_fw_responder

Overview:
AHB-Lite subordinate (responder) that serves the MCSE control unit's AHB requester port. It backs a word-addressed register-file memory holding firmware image blocks and boot data. The block sits on the system-side interconnect opposite the MCSE requester. It supports single transfers and INCR bursts, configurable wait states, byte/halfword/word writes, and a lockable read-only firmware region.

Parameters:
pAHB_ADDR_WIDTH, 32, address width
pAHB_DATA_WIDTH, 32, data width (fixed 32; hsize > 2 is illegal)
pMEM_WORDS, 256, memory depth in 32-bit words
pBASE_ADDR, 32'h0000_0000, byte base address of the window
pRO_WORDS, 72, words [0..pRO_WORDS-1] are the firmware region (9 x 256-bit blocks)
pWAIT_STATES, 1, data-phase wait cycles per OKAY transfer (0..7)

Ports:
clk  in  1  clock
rst  in  1  reset
I_hsel  in  1  slave select
I_haddr  in  pAHB_ADDR_WIDTH  address
I_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
I_hwrite  in  1  1=write
I_hsize  in  3  transfer size
I_hburst  in  3  burst type (accepted, not checked)
I_hprot  in  4  protection (ignored)
I_hmastlock  in  1  locked transfer (ignored)
I_hnonsec  in  1  non-secure access
I_hwdata  in  pAHB_DATA_WIDTH  write data
I_hready  in  1  bus ready (previous data phase complete)
wp_lock  in  1  1=firmware region read-only
O_hrdata  out  pAHB_DATA_WIDTH  read data
O_hreadyout  out  1  this slave's ready
O_hresp  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset is synchronous and active-high on rst (rst sampled on clk rising edge). On reset: O_hreadyout=1, O_hresp=0, O_hrdata=0, state IDLE, wait counter 0. Memory contents are not reset.
- Address phase is accepted when I_hsel & I_hready & I_htrans[1] are all 1. The block latches addr, write, size, and nonsec.
- A selected IDLE or BUSY transfer, or an unselected cycle, gets a zero-wait OKAY response with no side effects.
- An accepted transfer is an error if any of the following holds:
  - the offset (haddr - pBASE_ADDR) is at or beyond pMEM_WORDS*4;
  - hsize > 2;
  - the address is misaligned for hsize;
  - it is a write to the firmware region while wp_lock=1;
  - it is a write to the firmware region with hnonsec=1.
- States:
  - IDLE: O_hreadyout=1, O_hresp=0. Legal accept goes to WAIT if pWAIT_STATES>0, else DATA. Error accept goes to ERR1.
  - WAIT: O_hreadyout=0, O_hresp=0. Counts pWAIT_STATES cycles, then goes to DATA.
  - DATA: O_hreadyout=1, O_hresp=0.
    - Read: O_hrdata = mem[word]; O_hrdata is 0 in all other states.
    - Write: I_hwdata is written on this edge with byte lanes selected by hsize and addr[1:0].
    - A new accept in the same cycle (pipelined) goes to WAIT/DATA/ERR1; otherwise IDLE.
  - ERR1: O_hreadyout=0, O_hresp=1. Always goes to ERR2.
  - ERR2: O_hreadyout=1, O_hresp=1. Accepts a new address phase exactly like DATA. Per AHB, the requester may instead drive IDLE.
- An errored write never modifies memory.
- A lock change (wp_lock) takes effect on the next address phase. A transfer already accepted keeps its decision.
- Reset mid-transfer (WAIT/ERR1) abandons it: no write occurs and the block returns to IDLE.
- Back-to-back bursts sustain 1 transfer per (pWAIT_STATES+1) cycles.

Optional Feature:
MCSE_FW_RESP_ERRCNT_EN.
- Defined: adds output O_err_cnt [7:0]. It increments on each ERR1 entry, saturates at 8'hFF, and resets to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then idle -> O_hreadyout=1, O_hresp=0, O_hrdata=0.
- NONSEQ word write 32'hDEAD_BEEF to 0x100, then read 0x100, with pWAIT_STATES=1 -> hreadyout low 1 cycle per transfer; read returns 32'hDEAD_BEEF.
- Byte write 8'hA5 to 0x103 over word 32'h1122_3344 -> read returns 32'hA522_3344.
- wp_lock=1, write to 0x040 -> ERR1 then ERR2 (hresp=1, hreadyout 0 then 1); the next read of 0x040 is unchanged. An out-of-range read at 0x400 also errors.
- 8-beat INCR read from 0x000 with pWAIT_STATES=0 -> 8 consecutive data cycles with hreadyout=1 and correct words.
- rst asserted during WAIT of a write -> outputs return to reset values and memory is unchanged; with the macro defined, O_err_cnt=0.

Source files
------------

// File: rtl/mcse_ahb_fw_responder.sv
// AHB-Lite responder backing MCSE firmware/boot memory with a lockable RO region.
// Optional error counter output O_err_cnt: define MCSE_FW_RESP_ERRCNT_EN.

module mcse_ahb_fw_responder #(
   parameter int unsigned pAHB_ADDR_WIDTH = 32,
   parameter int unsigned pAHB_DATA_WIDTH = 32,
   parameter int unsigned pMEM_WORDS = 256,
   parameter logic [pAHB_ADDR_WIDTH-1:0] pBASE_ADDR = '0,
   parameter int unsigned pRO_WORDS = 72,
   parameter int unsigned pWAIT_STATES = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       I_hsel,
   input  logic [pAHB_ADDR_WIDTH-1:0] I_haddr,
   input  logic [1:0]                 I_htrans,
   input  logic                       I_hwrite,
   input  logic [2:0]                 I_hsize,
   input  logic [2:0]                 I_hburst,
   input  logic [3:0]                 I_hprot,
   input  logic                       I_hmastlock,
   input  logic                       I_hnonsec,
   input  logic [pAHB_DATA_WIDTH-1:0] I_hwdata,
   input  logic                       I_hready,
   input  logic                       wp_lock,
`ifdef MCSE_FW_RESP_ERRCNT_EN
   output logic [7:0]                 O_err_cnt,
`endif
   output logic [pAHB_DATA_WIDTH-1:0] O_hrdata,
   output logic                       O_hreadyout,
   output logic                       O_hresp
);

   localparam int unsigned WW  = $clog2(pMEM_WORDS);
   localparam int unsigned WW1 = WW + 1;
   localparam logic [pAHB_ADDR_WIDTH-1:0] LIMIT =
      pAHB_ADDR_WIDTH'(pMEM_WORDS * 4);
   localparam logic [WW:0] RO_END = WW1'(pRO_WORDS);
   localparam logic [2:0]  WS     = 3'(pWAIT_STATES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t state;
   logic [2:0]    wcnt;
   logic [WW-1:0] r_word;
   logic          r_write;
   logic [1:0]    r_size;
   logic [1:0]    r_lane;
   logic          hreadyout_q;
   logic          hresp_q;

   logic [pAHB_DATA_WIDTH-1:0] mem [pMEM_WORDS];

   logic [pAHB_ADDR_WIDTH-1:0] off;
   logic [WW-1:0] a_word;
   logic          accept;
   logic          ro_hit;
   logic          misal;
   logic          bad;
   logic [3:0]    be;
   logic          wr_en;
   logic          unused;

   assign unused = ^{I_hburst, I_hprot, I_hmastlock};

   assign off    = I_haddr - pBASE_ADDR;
   assign a_word = off[WW+1:2];
   assign accept = I_hsel & I_hready & I_htrans[1];
   assign ro_hit = {1'b0, a_word} < RO_END;

   always_comb begin
      misal = 1'b0;
      unique case (1'b1)
         I_hsize == 3'd1: misal = off[0];
         I_hsize == 3'd2: misal = |off[1:0];
         default:         misal = 1'b0;
      endcase
   end

   // lock/nonsec are judged here, at the address phase, and never again
   assign bad = (off >= LIMIT) | (I_hsize > 3'd2) | misal |
                (I_hwrite & ro_hit & (wp_lock | I_hnonsec));

   always_comb begin
      be = 4'b1111;
      unique case (1'b1)
         r_size == 2'd0: be = 4'b0001 << r_lane;
         r_size == 2'd1: be = r_lane[1] ? 4'b1100 : 4'b0011;
         default:        be = 4'b1111;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wcnt        <= '0;
         r_word      <= '0;
         r_write     <= 1'b0;
         r_size      <= '0;
         r_lane      <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
`ifdef MCSE_FW_RESP_ERRCNT_EN
         O_err_cnt   <= '0;
`endif
      end else begin
         unique case (state)
            S_WAIT: begin
               if (wcnt == 3'd0) begin
                  state       <= S_DATA;
                  hreadyout_q <= 1'b1;
               end else begin
                  wcnt <= wcnt - 3'd1;
               end
            end
            S_ERR1: begin
               state       <= S_ERR2;
               hreadyout_q <= 1'b1;
            end
            default: begin
               if (accept) begin
                  r_word  <= a_word;
                  r_write <= I_hwrite;
                  r_size  <= I_hsize[1:0];
                  r_lane  <= off[1:0];
                  if (bad) begin
                     state       <= S_ERR1;
                     hreadyout_q <= 1'b0;
                     hresp_q     <= 1'b1;
`ifdef MCSE_FW_RESP_ERRCNT_EN
                     if (O_err_cnt != 8'hFF)
                        O_err_cnt <= O_err_cnt + 8'd1;
`endif
                  end else if (WS != 3'd0) begin
                     state       <= S_WAIT;
                     wcnt        <= WS - 3'd1;
                     hreadyout_q <= 1'b0;
                     hresp_q     <= 1'b0;
                  end else begin
                     state       <= S_DATA;
                     hreadyout_q <= 1'b1;
                     hresp_q     <= 1'b0;
                  end
               end else begin
                  state       <= S_IDLE;
                  hreadyout_q <= 1'b1;
                  hresp_q     <= 1'b0;
               end
            end
         endcase
      end
   end

   // write data is taken in the final data-phase cycle
   assign wr_en = (state == S_DATA) & r_write & ~rst;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b])
               mem[r_word][8*b +: 8] <= I_hwdata[8*b +: 8];
         end
      end
   end

   assign O_hrdata    = (state == S_DATA && !r_write) ? mem[r_word] : '0;
   assign O_hreadyout = hreadyout_q;
   assign O_hresp     = hresp_q;

endmodule

// File: tb/tb_mcse_ahb_fw_responder.sv
// Self-checking bench: directed table, randomized transfers vs. reference model,
// plus hand sequences for reset, lock timing and zero-wait INCR8 bursts.

module tb_mcse_ahb_fw_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        hsel, hwrite, hnonsec, hready, wp_lock;
   logic [31:0] haddr, hwdata, hrdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hreadyout, hresp;

   logic        b_hsel, b_hwrite, b_hready;
   logic [31:0] b_haddr, b_hwdata, b_hrdata;
   logic [1:0]  b_htrans;
   logic        b_hreadyout, b_hresp;

`ifdef MCSE_FW_RESP_ERRCNT_EN
   logic [7:0] err_cnt, b_err_cnt;
`endif

   assign hready   = hreadyout;
   assign b_hready = b_hreadyout;

   mcse_ahb_fw_responder #(.pWAIT_STATES(1)) u1 (
      .clk(clk), .rst(rst), .I_hsel(hsel), .I_haddr(haddr),
      .I_htrans(htrans), .I_hwrite(hwrite), .I_hsize(hsize),
      .I_hburst(3'b000), .I_hprot(4'b0011), .I_hmastlock(1'b0),
      .I_hnonsec(hnonsec), .I_hwdata(hwdata), .I_hready(hready),
      .wp_lock(wp_lock),
`ifdef MCSE_FW_RESP_ERRCNT_EN
      .O_err_cnt(err_cnt),
`endif
      .O_hrdata(hrdata), .O_hreadyout(hreadyout), .O_hresp(hresp)
   );

   mcse_ahb_fw_responder #(.pWAIT_STATES(0)) u0 (
      .clk(clk), .rst(rst), .I_hsel(b_hsel), .I_haddr(b_haddr),
      .I_htrans(b_htrans), .I_hwrite(b_hwrite), .I_hsize(3'd2),
      .I_hburst(3'b101), .I_hprot(4'b0011), .I_hmastlock(1'b0),
      .I_hnonsec(1'b0), .I_hwdata(b_hwdata), .I_hready(b_hready),
      .wp_lock(1'b0),
`ifdef MCSE_FW_RESP_ERRCNT_EN
      .O_err_cnt(b_err_cnt),
`endif
      .O_hrdata(b_hrdata), .O_hreadyout(b_hreadyout), .O_hresp(b_hresp)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] model [256];
   int model_errs = 0;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [2:0]  sz;
      logic [31:0] d;
      logic        ns;
      logic        lk;
      logic        e_err;
      logic [31:0] e_rd;
   } vec_t;

   vec_t tbl[20];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic model_err(input logic w, input logic [31:0] a,
                                      input logic [2:0] sz, input logic ns,
                                      input logic lk);
      int unsigned off = a;
      logic e = 1'b0;
      if (off >= 256 * 4) e = 1'b1;
      if (sz > 3'd2) e = 1'b1;
      else if (off % (1 << sz) != 0) e = 1'b1;
      if (w && off / 4 < 72 && (lk || ns)) e = 1'b1;
      return e;
   endfunction

   function automatic logic [31:0] pat(input int i);
      return 32'h5A00_0000 + 32'(i) * 32'h0101_0101;
   endfunction

   task automatic xfer(input logic w, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] d,
                       input logic ns, input logic lk_ap, input logic lk_dp,
                       output logic [31:0] rd, output logic [1:0] rs,
                       output int waits);
      logic done = 1'b0;
      hsel = 1'b1; htrans = 2'd2; haddr = a; hwrite = w;
      hsize = sz; hnonsec = ns; wp_lock = lk_ap;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'd0; hwdata = d; wp_lock = lk_dp;
      waits = 0; rs = 2'b00; rd = '0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) rs[1] = hresp;
         if (hreadyout) begin
            rs[0] = hresp; rd = hrdata; done = 1'b1;
            break;
         end
         waits++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL timeout: hreadyout stuck at %b expected 1", hreadyout);
      end
   endtask

   task automatic apply(input string nm, input logic w, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] d,
                        input logic ns, input logic lk, input logic e_err,
                        input logic [31:0] e_rd);
      logic [31:0] rd;
      logic [1:0]  rs;
      int          waits;
      int unsigned off;
      xfer(w, a, sz, d, ns, lk, lk, rd, rs, waits);
      check({nm, "_resp"}, 32'(rs), e_err ? 32'd3 : 32'd0);
      check({nm, "_waits"}, 32'(waits), 32'd1);
      check({nm, "_rdata"}, rd, e_rd);
      if (e_err) begin
         if (model_errs < 255) model_errs++;
      end else if (w) begin
         off = a;
         for (int b = 0; b < 4; b++)
            if (b >= off % 4 && b < off % 4 + (1 << sz))
               model[off / 4][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   task automatic apply_model(input string nm, input logic w,
                              input logic [31:0] a, input logic [2:0] sz,
                              input logic [31:0] d, input logic ns,
                              input logic lk);
      logic e;
      logic [31:0] exp;
      e = model_err(w, a, sz, ns, lk);
      exp = (!e && !w) ? model[a / 4] : 32'd0;
      apply(nm, w, a, sz, d, ns, lk, e, exp);
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  rs;
      int          waits;
      logic [31:0] ra, rdat;
      logic [2:0]  rsz;
      logic        rw, rns, rlk;

      tbl[0]  = '{1, 32'h100, 2, 32'hDEAD_BEEF, 0, 0, 0, 32'h0};
      tbl[1]  = '{0, 32'h100, 2, 32'h0, 0, 0, 0, 32'hDEAD_BEEF};
      tbl[2]  = '{1, 32'h100, 2, 32'h1122_3344, 0, 0, 0, 32'h0};
      tbl[3]  = '{1, 32'h103, 0, 32'hA500_0000, 0, 0, 0, 32'h0};
      tbl[4]  = '{0, 32'h100, 2, 32'h0, 0, 0, 0, 32'hA522_3344};
      tbl[5]  = '{1, 32'h040, 2, 32'hFFFF_FFFF, 0, 1, 1, 32'h0};
      tbl[6]  = '{0, 32'h040, 2, 32'h0, 0, 1, 0, 32'hC0DE_0010};
      tbl[7]  = '{0, 32'h400, 2, 32'h0, 0, 0, 1, 32'h0};
      tbl[8]  = '{0, 32'h101, 1, 32'h0, 0, 0, 1, 32'h0};
      tbl[9]  = '{0, 32'h100, 3, 32'h0, 0, 0, 1, 32'h0};
      tbl[10] = '{1, 32'h000, 2, 32'h1234_0000, 1, 0, 1, 32'h0};
      tbl[11] = '{1, 32'h120, 2, 32'h1234_5678, 1, 1, 0, 32'h0};
      tbl[12] = '{0, 32'h120, 2, 32'h0, 0, 1, 0, 32'h1234_5678};
      tbl[13] = '{1, 32'h122, 1, 32'hBEEF_0000, 0, 0, 0, 32'h0};
      tbl[14] = '{0, 32'h120, 2, 32'h0, 0, 0, 0, 32'hBEEF_5678};
      tbl[15] = '{1, 32'h3FC, 2, 32'hCAFE_F00D, 0, 0, 0, 32'h0};
      tbl[16] = '{0, 32'h3FC, 2, 32'h0, 0, 0, 0, 32'hCAFE_F00D};
      tbl[17] = '{0, 32'h11C, 2, 32'h0, 0, 1, 0, 32'hC0DE_0047};
      tbl[18] = '{1, 32'h11C, 2, 32'h0BAD_0BAD, 0, 1, 1, 32'h0};
      tbl[19] = '{0, 32'h3FD, 0, 32'h0, 0, 0, 0, 32'hCAFE_F00D};

      rst = 1'b1; hsel = 0; htrans = 0; haddr = 0; hwrite = 0; hsize = 2;
      hnonsec = 0; hwdata = 0; wp_lock = 0;
      b_hsel = 0; b_htrans = 0; b_haddr = 0; b_hwrite = 0; b_hwdata = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(hreadyout), 32'd1);
      check("rst_resp", 32'(hresp), 32'd0);
      check("rst_rdata", hrdata, 32'd0);
      check("rst0_ready", 32'(b_hreadyout), 32'd1);
`ifdef MCSE_FW_RESP_ERRCNT_EN
      check("rst_errcnt", 32'(err_cnt), 32'd0);
`endif

      // selected IDLE then BUSY: zero-wait OKAY
      hsel = 1; htrans = 2'd0; haddr = 32'h100;
      @(negedge clk);
      check("idle_ready", 32'(hreadyout), 32'd1);
      htrans = 2'd1;
      @(negedge clk);
      check("busy_ready", 32'(hreadyout), 32'd1);
      check("busy_resp", 32'(hresp), 32'd0);
      hsel = 0; htrans = 0;

      for (int i = 0; i < 256; i++)
         apply("init", 1, 32'(i * 4), 2, 32'hC0DE_0000 | 32'(i),
               0, 0, 0, 32'h0);

      for (int i = 0; i < 20; i++)
         apply($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].sz,
               tbl[i].d, tbl[i].ns, tbl[i].lk, tbl[i].e_err, tbl[i].e_rd);

      // lock raised after accept: write still lands
      xfer(1, 32'h044, 2, 32'h7777_7777, 0, 0, 1, rd, rs, waits);
      check("lk_late_resp", 32'(rs), 32'd0);
      model[17] = 32'h7777_7777;
      apply("lk_late_rd", 0, 32'h044, 2, 0, 0, 1, 0, 32'h7777_7777);
      // lock dropped after accept: error stands
      xfer(1, 32'h048, 2, 32'h8888_8888, 0, 1, 0, rd, rs, waits);
      check("lk_drop_resp", 32'(rs), 32'd3);
      if (model_errs < 255) model_errs++;
      apply("lk_drop_rd", 0, 32'h048, 2, 0, 0, 0, 0, 32'hC0DE_0012);

      for (int i = 0; i < 300; i++) begin
         rw  = 1'($urandom % 2);
         rsz = ($urandom % 8 == 0) ? 3'd3 : 3'($urandom % 3);
         ra  = 32'($urandom_range(0, 32'h47F));
         if ($urandom % 8 != 0) ra = ra & ~((32'd1 << rsz) - 32'd1);
         rns = ($urandom % 4 == 0);
         rlk = 1'($urandom % 2);
         rdat = $urandom;
         apply_model("rnd", rw, ra, rsz, rdat, rns, rlk);
      end
`ifdef MCSE_FW_RESP_ERRCNT_EN
      check("errcnt", 32'(err_cnt), 32'(model_errs));
`endif

      // reset during WAIT of a write
      hsel = 1; htrans = 2'd2; haddr = 32'h200; hwrite = 1;
      hsize = 2; hnonsec = 0; wp_lock = 0;
      @(posedge clk); #1;
      hsel = 0; htrans = 0; hwdata = 32'h0BAD_F00D;
      @(negedge clk);
      check("rstw_wait", 32'(hreadyout), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rstw_ready", 32'(hreadyout), 32'd1);
      check("rstw_resp", 32'(hresp), 32'd0);
      check("rstw_rdata", hrdata, 32'd0);
`ifdef MCSE_FW_RESP_ERRCNT_EN
      check("rstw_errcnt", 32'(err_cnt), 32'd0);
`endif
      model_errs = 0;
      apply_model("rstw_mem", 0, 32'h200, 2, 0, 0, 0);

      // zero-wait INCR8 write then read
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            b_hsel = 1; b_htrans = (i == 0) ? 2'd2 : 2'd3;
            b_haddr = 32'(i * 4); b_hwrite = 1;
         end else begin
            b_hsel = 0; b_htrans = 0;
         end
         if (i > 0) b_hwdata = pat(i - 1);
         @(posedge clk); @(negedge clk);
         if (i < 8) check("bw_ready", 32'(b_hreadyout), 32'd1);
      end
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            b_hsel = 1; b_htrans = (i == 0) ? 2'd2 : 2'd3;
            b_haddr = 32'(i * 4); b_hwrite = 0;
         end else begin
            b_hsel = 0; b_htrans = 0;
         end
         @(posedge clk); @(negedge clk);
         if (i < 8) begin
            check("br_ready", 32'(b_hreadyout), 32'd1);
            check("br_resp", 32'(b_hresp), 32'd0);
            check($sformatf("br_data%0d", i), b_hrdata, pat(i));
         end else begin
            check("br_idle_rdata", b_hrdata, 32'd0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
